// File: rtl/cva6_gshare_bht.sv
// Branch history table with 2-bit saturating counters and optional gshare indexing.
// Counters are cleared row by row by an init FSM after reset and flush, never by reset itself.

module cva6_gshare_bht_lane #(
  parameter int unsigned NR_ROWS = 16,
  parameter int unsigned RI      = 4
) (
  input  logic          clk_i,
  input  logic          init_we_i,
  input  logic [RI-1:0] init_row_i,
  input  logic          upd_we_i,
  input  logic [RI-1:0] upd_row_i,
  input  logic          upd_taken_i,
  input  logic [RI-1:0] rd_row_i,
  output logic [1:0]    rd_cnt_o
);
  logic [NR_ROWS-1:0][1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (init_we_i) begin
      cnt_d[init_row_i] = 2'b01;
    end else if (upd_we_i) begin
      if (upd_taken_i && cnt_q[upd_row_i] != 2'b11)
        cnt_d[upd_row_i] = cnt_q[upd_row_i] + 2'd1;
      else if (!upd_taken_i && cnt_q[upd_row_i] != 2'b00)
        cnt_d[upd_row_i] = cnt_q[upd_row_i] - 2'd1;
    end
  end

  always_ff @(posedge clk_i) cnt_q <= cnt_d;

  assign rd_cnt_o = cnt_q[rd_row_i];
endmodule

module cva6_gshare_bht #(
  parameter int unsigned VLEN       = 32,
  parameter int unsigned NR_ENTRIES = 32,
  parameter int unsigned ROW        = 2,
  parameter int unsigned HIST_BITS  = 3,
  parameter int unsigned MODE       = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 debug_mode_i,
  input  logic [VLEN-1:0]      vpc_i,
  input  logic                 bht_update_valid_i,
  input  logic [VLEN-1:0]      bht_update_pc_i,
  input  logic                 bht_update_taken_i,
  input  logic [HIST_BITS-1:0] bht_update_hist_i,
  output logic [ROW-1:0]       bht_prediction_valid_o,
  output logic [ROW-1:0]       bht_prediction_taken_o,
  output logic [HIST_BITS-1:0] ghr_o,
  output logic                 init_done_o
);
  localparam int unsigned NR_ROWS = NR_ENTRIES / ROW;
  localparam int unsigned RI      = $clog2(NR_ROWS);
  localparam int unsigned CB      = (ROW > 1) ? $clog2(ROW) : 0;
  localparam int unsigned CBW     = (CB > 0) ? CB : 1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [RI-1:0]         init_idx_q, init_idx_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d, ghr_shift;
  logic [RI-1:0]         lk_h, up_h, lk_row, up_row;
  logic [CBW-1:0]        up_col;
  logic                  init_we, upd_acc;
  logic [ROW-1:0][1:0]   rd_cnt;
  logic                  unused_bits;

  // History folded to the row-index width: zero-extended or low bits kept
  generate
    if (MODE == 0) begin : g_bimodal
      assign lk_h = '0;
      assign up_h = '0;
    end else if (HIST_BITS >= RI) begin : g_trunc
      assign lk_h = ghr_q[RI-1:0];
      assign up_h = bht_update_hist_i[RI-1:0];
    end else begin : g_zext
      assign lk_h = {{(RI-HIST_BITS){1'b0}}, ghr_q};
      assign up_h = {{(RI-HIST_BITS){1'b0}}, bht_update_hist_i};
    end
    if (CB > 0) begin : g_col
      assign up_col = bht_update_pc_i[1 +: CB];
    end else begin : g_nocol
      assign up_col = '0;
    end
    if (HIST_BITS == 1) begin : g_h1
      assign ghr_shift = bht_update_taken_i;
    end else begin : g_hn
      assign ghr_shift = {ghr_q[HIST_BITS-2:0], bht_update_taken_i};
    end
  endgenerate

  assign lk_row  = vpc_i[CB+1 +: RI] ^ lk_h;
  assign up_row  = bht_update_pc_i[CB+1 +: RI] ^ up_h;
  assign init_we = (state_q == INIT) && !rst_i && !flush_i;
  assign upd_acc = (state_q == RUN) && bht_update_valid_i && !debug_mode_i && !flush_i && !rst_i;
  assign unused_bits = ^{vpc_i, bht_update_pc_i, bht_update_hist_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = '0;
    ghr_d      = ghr_q;
    if (flush_i) begin
      state_d = INIT;
      ghr_d   = '0;
    end else begin
      case (state_q)
        INIT: begin
          init_idx_d = init_idx_q + 1'b1;
          if (init_idx_q == RI'(NR_ROWS-1)) state_d = RUN;
        end
        RUN: if (upd_acc) ghr_d = ghr_shift;
        default: state_d = INIT;
      endcase
    end
  end

  always_comb begin
    init_done_o            = 1'b0;
    bht_prediction_valid_o = '0;
    bht_prediction_taken_o = '0;
    if (state_q == RUN) begin
      init_done_o            = 1'b1;
      bht_prediction_valid_o = '1;
      for (int i = 0; i < int'(ROW); i++) bht_prediction_taken_o[i] = rd_cnt[i][1];
    end
  end

  assign ghr_o = ghr_q;

  for (genvar i = 0; i < int'(ROW); i++) begin : g_lane
    cva6_gshare_bht_lane #(.NR_ROWS(NR_ROWS), .RI(RI)) u_lane (
      .clk_i      (clk_i),
      .init_we_i  (init_we),
      .init_row_i (init_idx_q),
      .upd_we_i   (upd_acc && (up_col == CBW'(i))),
      .upd_row_i  (up_row),
      .upd_taken_i(bht_update_taken_i),
      .rd_row_i   (lk_row),
      .rd_cnt_o   (rd_cnt[i])
    );
  end
endmodule
